// File: rtl/nes_receiver.sv
// NES/SNES controller receiver: latches the pad, clocks out NUM_BITS serial
// bits through a 2-flop synchronizer and publishes active-high button state.
module nes_receiver #(
  parameter int NUM_BITS     = 8,
  parameter int LATCH_CYCLES = 300,
  parameter int HALF_CYCLES  = 150
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        nes_data,
  output logic        nes_latch,
  output logic        nes_clk,
  output logic [15:0] buttons,
  output logic        valid,
  output logic        busy
);

  localparam int MAX_CYCLES = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam int IDX_W      = $clog2(NUM_BITS);

  localparam logic [CNT_W-1:0] LATCH_LOAD = CNT_W'(LATCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD  = CNT_W'(HALF_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_BITS - 1);

  if (NUM_BITS != 8 && NUM_BITS != 16) begin : g_bad_num_bits
    $error("nes_receiver: NUM_BITS must be 8 or 16");
  end

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    CLK_LOW,
    CLK_HIGH,
    DONE
  } state_t;

  state_t               state;
  logic [1:0]           data_sync;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic [NUM_BITS-1:0]  shift;
  logic [15:0]          shift_ext_n;

  always_comb begin
    shift_ext_n                 = '0;
    shift_ext_n[NUM_BITS-1:0]   = ~shift;
  end

  // Counter reloads on every state entry and counts down to zero, so each
  // phase length is independent of the previous one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      data_sync <= '1;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      nes_latch <= 1'b0;
      nes_clk   <= 1'b0;
      buttons   <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      data_sync <= {data_sync[0], nes_data};
      valid     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= LATCH;
            cnt       <= LATCH_LOAD;
            nes_latch <= 1'b1;
            busy      <= 1'b1;
          end
        end
        LATCH: begin
          if (cnt == '0) begin
            state     <= CLK_LOW;
            cnt       <= HALF_LOAD;
            idx       <= '0;
            nes_latch <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        CLK_LOW: begin
          if (cnt == '0) begin
            shift[idx] <= data_sync[1];
            state      <= CLK_HIGH;
            cnt        <= HALF_LOAD;
            nes_clk    <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        CLK_HIGH: begin
          if (cnt == '0) begin
            nes_clk <= 1'b0;
            if (idx == LAST_IDX) begin
              // buttons and valid are registered on DONE entry so both are
              // visible together during the DONE cycle.
              state   <= DONE;
              buttons <= shift_ext_n;
              valid   <= 1'b1;
            end else begin
              idx   <= idx + IDX_W'(1);
              state <= CLK_LOW;
              cnt   <= HALF_LOAD;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          nes_latch <= 1'b0;
          nes_clk   <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nes_receiver.sv
// Directed bench for nes_receiver: 8-bit and 16-bit instances driven by a
// behavioural shift-register controller model.
module tb_nes_receiver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start8, start16;
  logic        nes_data8, nes_data16;
  logic        nes_latch8, nes_clk8, valid8, busy8;
  logic        nes_latch16, nes_clk16, valid16, busy16;
  logic [15:0] buttons8, buttons16;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  nes_receiver #(.NUM_BITS(8), .LATCH_CYCLES(4), .HALF_CYCLES(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .nes_data(nes_data8),
    .nes_latch(nes_latch8), .nes_clk(nes_clk8), .buttons(buttons8),
    .valid(valid8), .busy(busy8)
  );

  nes_receiver #(.NUM_BITS(16), .LATCH_CYCLES(4), .HALF_CYCLES(2)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .nes_data(nes_data16),
    .nes_latch(nes_latch16), .nes_clk(nes_clk16), .buttons(buttons16),
    .valid(valid16), .busy(busy16)
  );

  // Controller model: parallel load while latch is high, shift on nes_clk rise.
  logic [7:0]  pat8 = 8'hFF;
  logic [15:0] pat16 = 16'hFFFF;
  logic        conn8 = 1'b1, conn16 = 1'b1;
  logic [7:0]  sr8 = '1;
  logic [15:0] sr16 = '1;
  logic        rclk8_q = 1'b0, rclk16_q = 1'b0;

  always @(posedge clk) begin
    if (nes_latch8) sr8 <= pat8;
    else if (nes_clk8 && !rclk8_q) sr8 <= {1'b1, sr8[7:1]};
    rclk8_q <= nes_clk8;
    if (nes_latch16) sr16 <= pat16;
    else if (nes_clk16 && !rclk16_q) sr16 <= {1'b1, sr16[15:1]};
    rclk16_q <= nes_clk16;
  end

  assign nes_data8  = conn8  ? sr8[0]  : 1'b1;
  assign nes_data16 = conn16 ? sr16[0] : 1'b1;

  // Line monitor: pulse counts, phase widths, latch/clk overlap.
  int pulses8 = 0, pulses16 = 0, wbad8 = 0, wbad16 = 0, lbad8 = 0;
  int w8 = 0, w16 = 0, lw8 = 0, overlap = 0;
  logic mclk8_q = 1'b0, mclk16_q = 1'b0, mlat8_q = 1'b0;

  always @(negedge clk) begin
    if (nes_clk8 && !mclk8_q) pulses8 <= pulses8 + 1;
    if (nes_clk8) w8 <= w8 + 1;
    else if (mclk8_q) begin
      if (w8 != 2) wbad8 <= wbad8 + 1;
      w8 <= 0;
    end
    if (nes_clk16 && !mclk16_q) pulses16 <= pulses16 + 1;
    if (nes_clk16) w16 <= w16 + 1;
    else if (mclk16_q) begin
      if (w16 != 2) wbad16 <= wbad16 + 1;
      w16 <= 0;
    end
    if (nes_latch8) lw8 <= lw8 + 1;
    else if (mlat8_q) begin
      if (lw8 != 4) lbad8 <= lbad8 + 1;
      lw8 <= 0;
    end
    if ((nes_latch8 && nes_clk8) || (nes_latch16 && nes_clk16)) overlap <= overlap + 1;
    mclk8_q  <= nes_clk8;
    mclk16_q <= nes_clk16;
    mlat8_q  <= nes_latch8;
  end

  // Called just after the start-sampling edge; cycle n is the n-th negedge.
  task automatic track8(input int max_cycles, output int first_valid, output int nvalid);
    first_valid = -1;
    nvalid      = 0;
    for (int n = 1; n <= max_cycles; n++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (valid8) begin
        nvalid++;
        if (first_valid < 0) first_valid = n;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start8 = 1'b0; start16 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if (nes_latch8 !== 1'b0) begin fails++; $display("FAIL reset_latch8 got %b expected 0", nes_latch8); end
    tests++; if (nes_clk8 !== 1'b0) begin fails++; $display("FAIL reset_clk8 got %b expected 0", nes_clk8); end
    tests++; if (buttons8 !== 16'h0000) begin fails++; $display("FAIL reset_buttons8 got %h expected 0000", buttons8); end
    tests++; if (valid8 !== 1'b0) begin fails++; $display("FAIL reset_valid8 got %b expected 0", valid8); end
    tests++; if (busy8 !== 1'b0) begin fails++; $display("FAIL reset_busy8 got %b expected 0", busy8); end
    tests++; if ({nes_latch16, nes_clk16, valid16, busy16} !== 4'b0000) begin
      fails++; $display("FAIL reset_ctrl16 got %b expected 0000", {nes_latch16, nes_clk16, valid16, busy16});
    end
    tests++; if (buttons16 !== 16'h0000) begin fails++; $display("FAIL reset_buttons16 got %h expected 0000", buttons16); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_pattern();
    int fv, nv, p0, wb0, lb0;
    pat8 = 8'b0111_1110; conn8 = 1'b1;
    p0 = pulses8; wb0 = wbad8; lb0 = lbad8;
    @(negedge clk); start8 = 1'b1;
    @(posedge clk);
    track8(45, fv, nv);
    tests++; if (fv != 37) begin fails++; $display("FAIL pattern_latency got %0d expected 37", fv); end
    tests++; if (nv != 1) begin fails++; $display("FAIL pattern_valid_count got %0d expected 1", nv); end
    tests++; if (buttons8 !== 16'h0081) begin fails++; $display("FAIL pattern_buttons got %h expected 0081", buttons8); end
    tests++; if (pulses8 - p0 != 8) begin fails++; $display("FAIL pattern_pulses got %0d expected 8", pulses8 - p0); end
    tests++; if (wbad8 != wb0) begin fails++; $display("FAIL pattern_clk_width bad=%0d expected 0", wbad8 - wb0); end
    tests++; if (lbad8 != lb0) begin fails++; $display("FAIL pattern_latch_width bad=%0d expected 0", lbad8 - lb0); end
    tests++; if (busy8 !== 1'b0) begin fails++; $display("FAIL pattern_busy_after got %b expected 0", busy8); end
  endtask

  task automatic test_disconnected();
    int fv, nv;
    conn8 = 1'b0;
    @(negedge clk); start8 = 1'b1;
    @(posedge clk);
    track8(45, fv, nv);
    tests++; if (fv != 37) begin fails++; $display("FAIL discon_latency got %0d expected 37", fv); end
    tests++; if (buttons8 !== 16'h0000) begin fails++; $display("FAIL discon_buttons got %h expected 0000", buttons8); end
    conn8 = 1'b1;
  endtask

  task automatic test_restart_ignored();
    int fv = -1, nv = 0, busy_bad = 0;
    pat8 = 8'b0101_0101;
    @(negedge clk); start8 = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      start8 = (n == 10 || n == 20);
      if (n <= 37 && busy8 !== 1'b1) busy_bad++;
      if (valid8) begin
        nv++;
        if (fv < 0) fv = n;
      end
    end
    start8 = 1'b0;
    tests++; if (fv != 37) begin fails++; $display("FAIL restart_latency got %0d expected 37", fv); end
    tests++; if (nv != 1) begin fails++; $display("FAIL restart_valid_count got %0d expected 1", nv); end
    tests++; if (busy_bad != 0) begin fails++; $display("FAIL restart_busy low_cycles=%0d expected 0", busy_bad); end
    tests++; if (buttons8 !== 16'h00AA) begin fails++; $display("FAIL restart_buttons got %h expected 00aa", buttons8); end
  endtask

  task automatic test_reset_mid_poll();
    int fv, nv;
    pat8 = 8'h00;
    @(negedge clk); start8 = 1'b1;
    @(posedge clk);
    track8(45, fv, nv);
    tests++; if (buttons8 !== 16'h00FF) begin fails++; $display("FAIL midrst_prior_buttons got %h expected 00ff", buttons8); end
    @(negedge clk); start8 = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      start8 = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    tests++; if (nes_clk8 !== 1'b0) begin fails++; $display("FAIL midrst_clk got %b expected 0", nes_clk8); end
    tests++; if (nes_latch8 !== 1'b0) begin fails++; $display("FAIL midrst_latch got %b expected 0", nes_latch8); end
    tests++; if (buttons8 !== 16'h0000) begin fails++; $display("FAIL midrst_buttons got %h expected 0000", buttons8); end
    tests++; if (busy8 !== 1'b0) begin fails++; $display("FAIL midrst_busy got %b expected 0", busy8); end
    rst_n = 1'b1;
    track8(45, fv, nv);
    tests++; if (nv != 0) begin fails++; $display("FAIL midrst_no_valid got %0d expected 0", nv); end
    tests++; if (busy8 !== 1'b0) begin fails++; $display("FAIL midrst_idle_wait got %b expected 0", busy8); end
  endtask

  task automatic test_back_to_back();
    int fv, nv;
    pat8 = 8'b0111_1110;
    @(negedge clk); start8 = 1'b1;
    @(posedge clk);
    track8(37, fv, nv);
    tests++; if (fv != 37) begin fails++; $display("FAIL b2b_first_latency got %0d expected 37", fv); end
    tests++; if (buttons8 !== 16'h0081) begin fails++; $display("FAIL b2b_first_buttons got %h expected 0081", buttons8); end
    // start held from the DONE cycle into the first IDLE cycle
    pat8 = 8'b1111_1100;
    start8 = 1'b1;
    @(negedge clk);
    tests++; if (busy8 !== 1'b0) begin fails++; $display("FAIL b2b_done_start_ignored busy got %b expected 0", busy8); end
    @(posedge clk);
    track8(45, fv, nv);
    tests++; if (fv != 37) begin fails++; $display("FAIL b2b_second_latency got %0d expected 37", fv); end
    tests++; if (nv != 1) begin fails++; $display("FAIL b2b_second_valid_count got %0d expected 1", nv); end
    tests++; if (buttons8 !== 16'h0003) begin fails++; $display("FAIL b2b_second_buttons got %h expected 0003", buttons8); end
  endtask

  task automatic test_sixteen_bits();
    int fv = -1, nv = 0, p0, wb0;
    pat16 = 16'hF0F0; conn16 = 1'b1;
    p0 = pulses16; wb0 = wbad16;
    @(negedge clk); start16 = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      start16 = 1'b0;
      if (valid16) begin
        nv++;
        if (fv < 0) fv = n;
      end
    end
    tests++; if (fv != 69) begin fails++; $display("FAIL snes_latency got %0d expected 69", fv); end
    tests++; if (nv != 1) begin fails++; $display("FAIL snes_valid_count got %0d expected 1", nv); end
    tests++; if (buttons16 !== 16'h0F0F) begin fails++; $display("FAIL snes_buttons got %h expected 0f0f", buttons16); end
    tests++; if (pulses16 - p0 != 16) begin fails++; $display("FAIL snes_pulses got %0d expected 16", pulses16 - p0); end
    tests++; if (wbad16 != wb0) begin fails++; $display("FAIL snes_clk_width bad=%0d expected 0", wbad16 - wb0); end
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_disconnected();
    test_restart_ignored();
    test_reset_mid_poll();
    test_back_to_back();
    test_sixteen_bits();
    tests++; if (overlap != 0) begin fails++; $display("FAIL latch_clk_overlap got %0d cycles expected 0", overlap); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
